// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a power-of-two TX FIFO with level interrupt
module uart_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int THRESH = 2,
    parameter int DIV_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_en,
    input  logic [DIV_W-1:0]         cfg_divisor,
    input  logic                     cfg_parity_en,
    input  logic                     cfg_parity_odd,
    input  logic                     cfg_stop2,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     busy,
    output logic                     tx_irq,
    output logic                     txd
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [AW-1:0]       wptr_q, rptr_q;
    logic [LW-1:0]       level_q;
    logic [DIV_W-1:0]    cnt_q, cnt_d, div_q, div_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [DATA_W-1:0]   sh_q, sh_d;
    logic                par_en_q, par_en_d, par_q, par_d, stop2_q, stop2_d;
    logic                txd_q, txd_d, irq_q;
    logic                push, pop, tick;

    assign wr_ready   = level_q < LW'(DEPTH);
    assign push       = wr_valid & wr_ready & ~flush;
    assign pop        = (state_q == IDLE) & cfg_en & (level_q != '0);
    assign tick       = cnt_q == div_q;
    assign fifo_level = level_q;
    assign busy       = state_q != IDLE;
    assign tx_irq     = irq_q;
    assign txd        = txd_q;

    // FIFO storage; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= wr_data;
    end

    // FIFO pointers, level and the registered low-level interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            irq_q   <= 1'b1;
        end else begin
            irq_q <= level_q <= LW'(THRESH);
            if (flush) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                level_q <= '0;
            end else begin
                wptr_q  <= push ? wptr_q + AW'(1) : wptr_q;
                rptr_q  <= pop ? rptr_q + AW'(1) : rptr_q;
                level_q <= level_q + LW'(push) - LW'(pop);
            end
        end
    end

    // Frame state, baud counter, shifter, per-frame config and registered line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            stop2_q  <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
            stop2_q  <= stop2_d;
            txd_q    <= txd_d;
        end
    end

    // Next-state logic; txd is computed from the next state so the line is glitch-free
    always_comb begin
        state_d  = state_q;
        cnt_d    = tick ? '0 : cnt_q + DIV_W'(1);
        div_d    = div_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        par_en_d = par_en_q;
        par_d    = par_q;
        stop2_d  = stop2_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (pop) begin
                    state_d  = START;
                    sh_d     = mem[rptr_q];
                    div_d    = cfg_divisor;
                    par_en_d = cfg_parity_en;
                    par_d    = ^mem[rptr_q] ^ cfg_parity_odd;
                    stop2_d  = cfg_stop2;
                end
            end
            START: state_d = tick ? DATA : START;
            DATA: begin
                if (tick) begin
                    if (bit_q == BW'(DATA_W - 1)) begin
                        state_d = par_en_q ? PARITY : STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BW'(1);
                        sh_d  = sh_q >> 1;
                    end
                end
            end
            PARITY: state_d = tick ? STOP : PARITY;
            STOP: begin
                if (tick) begin
                    if (stop2_q && bit_q == '0) bit_d = BW'(1);
                    else begin
                        state_d = IDLE;
                        bit_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        txd_d = (state_d == START) ? 1'b0 :
                (state_d == DATA)  ? sh_d[0] :
                (state_d == PARITY) ? par_d : 1'b1;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed stimulus against a queue-based line model of the UART TX FIFO
module tb_uart_tx_fifo;
    localparam int DEPTH  = 16;
    localparam int THRESH = 2;

    logic        clk, rst_n, cfg_en, cfg_parity_en, cfg_parity_odd, cfg_stop2;
    logic [15:0] cfg_divisor;
    logic        wr_valid, wr_ready, flush, busy, tx_irq, txd;
    logic [7:0]  wr_data;
    logic [4:0]  fifo_level;

    uart_tx_fifo dut (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_divisor(cfg_divisor),
        .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd), .cfg_stop2(cfg_stop2),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .flush(flush),
        .fifo_level(fifo_level), .busy(busy), .tx_irq(tx_irq), .txd(txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: software FIFO plus a per-cycle queue of line levels for the frame in flight
    logic [7:0] mq[$];
    logic       lq[$];
    logic       m_txd = 1'b1, m_busy = 1'b0, m_irq = 1'b1, m_idle = 1'b1;
    int         m_lvl;

    function automatic void push_frame(logic [7:0] d, int div, logic pen, logic podd, logic s2);
        logic b[$];
        b.push_back(1'b0);
        for (int i = 0; i < 8; i++) b.push_back(d[i]);
        if (pen) b.push_back(^d ^ podd);
        b.push_back(1'b1);
        if (s2) b.push_back(1'b1);
        for (int k = 0; k < b.size(); k++)
            for (int r = 0; r <= div; r++) lq.push_back(b[k]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            lq.delete();
            m_txd  = 1'b1;
            m_busy = 1'b0;
            m_irq  = 1'b1;
            m_idle = 1'b1;
        end else begin
            m_lvl = mq.size();
            if (lq.size() > 0) begin
                m_txd  = lq.pop_front();
                m_busy = 1'b1;
            end else if (m_idle && cfg_en && mq.size() > 0) begin
                push_frame(mq.pop_front(), int'(cfg_divisor), cfg_parity_en, cfg_parity_odd, cfg_stop2);
                m_txd  = lq.pop_front();
                m_busy = 1'b1;
            end else begin
                m_txd  = 1'b1;
                m_busy = 1'b0;
            end
            m_idle = !m_busy;
            if (flush) mq.delete();
            else if (wr_valid && m_lvl < DEPTH) mq.push_back(wr_data);
            m_irq = m_lvl <= THRESH;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("txd", txd, m_txd);
        chk("busy", busy, m_busy);
        chk("fifo_level", fifo_level, mq.size());
        chk("wr_ready", wr_ready, mq.size() < DEPTH);
        chk("tx_irq", tx_irq, m_irq);
    end

    logic cap[512];
    int   cap_len;

    task automatic wr(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("wait_busy", busy, 1'b1);
    endtask

    task automatic capture();
        cap_len = 0;
        wait_busy();
        while (busy && cap_len < 512) begin
            cap[cap_len] = txd;
            cap_len++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((busy || fifo_level != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", n < limit, 1'b1);
    endtask

    task automatic check_a5();
        logic [9:0] e = 10'b11_0100_1010;
        capture();
        chk("a5_len", cap_len, 40);
        for (int i = 0; i < 10; i++) begin
            chk("a5_bit_first", cap[i*4], e[i]);
            chk("a5_bit_last", cap[i*4+3], e[i]);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; cfg_en = 1'b0; cfg_divisor = 16'd3; cfg_parity_en = 1'b0;
        cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0; wr_valid = 1'b0; wr_data = '0; flush = 1'b0;
        @(negedge clk);
        chk("rst_txd", txd, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", wr_ready, 1'b1);
        chk("rst_irq", tx_irq, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        cfg_en = 1'b1;
        wr(8'hA5);
        check_a5();

        cfg_parity_en = 1'b1;
        wr(8'h03);
        capture();
        chk("even_len", cap_len, 44);
        chk("even_par", cap[38], 1'b0);
        cfg_parity_odd = 1'b1;
        wr(8'h03);
        capture();
        chk("odd_par", cap[38], 1'b1);
        cfg_parity_en = 1'b0;
        cfg_stop2 = 1'b1;
        wr(8'h03);
        capture();
        chk("stop2_len", cap_len, 44);
        chk("stop2_tail", cap[40], 1'b1);
        cfg_stop2 = 1'b0;
        cfg_parity_odd = 1'b0;

        cfg_en = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i + 16);
            @(negedge clk);
            if (i == 15) begin
                chk("full_ready", wr_ready, 1'b0);
                chk("full_level", fifo_level, 16);
            end
        end
        wr_valid = 1'b0;
        chk("level_after_17", fifo_level, 16);
        @(negedge clk);
        chk("full_irq", tx_irq, 1'b0);
        cfg_divisor = 16'd0;
        cfg_en = 1'b1;
        wait_idle(1000);

        cfg_en = 1'b0;
        cfg_divisor = 16'd1;
        wr(8'h11); wr(8'h22); wr(8'h33);
        cfg_en = 1'b1;
        wait_busy();
        n = 0;
        while (busy && n < 100) begin @(negedge clk); n++; end
        n = 0;
        while (!busy && n < 50) begin @(negedge clk); n++; end
        chk("idle_gap", n, 1);
        cfg_en = 1'b0;
        repeat (40) @(negedge clk);
        chk("en_off_busy", busy, 1'b0);
        chk("en_off_level", fifo_level, 1);
        cfg_en = 1'b1;
        wait_idle(200);

        cfg_en = 1'b0;
        cfg_divisor = 16'd2;
        wr(8'h01); wr(8'h02); wr(8'h04); wr(8'h08);
        cfg_en = 1'b1;
        wait_busy();
        repeat (5) @(negedge clk);
        cfg_divisor = 16'd7;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_level", fifo_level, 0);
        chk("flush_busy", busy, 1'b1);
        repeat (80) @(negedge clk);
        chk("flush_no_more", busy, 1'b0);
        cfg_divisor = 16'd3;

        wr(8'h00);
        wait_busy();
        repeat (6) @(negedge clk);
        chk("mid_data_txd", txd, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_txd", txd, 1'b1);
        chk("async_busy", busy, 1'b0);
        chk("async_level", fifo_level, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wr(8'hA5);
        check_a5();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data bits per frame (legal range 5..9).
REQ-002 SHALL have parameter DEPTH, default 16, meaning TX FIFO entries (power of two, at least 2).
REQ-003 SHALL have parameter THRESH, default 2, meaning FIFO level at or below which tx_irq asserts (less than DEPTH).
REQ-004 SHALL have parameter DIV_W, default 16, meaning divisor width.
REQ-005 clk  input  1  the single clock; all logic is on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 cfg_en  input  1  transmitter enable.
REQ-008 cfg_divisor  input  DIV_W  one bit period lasts cfg_divisor+1 clk cycles.
REQ-009 cfg_parity_en  input  1  1 inserts a parity bit.
REQ-010 cfg_parity_odd  input  1  1 selects odd parity, 0 selects even parity.
REQ-011 cfg_stop2  input  1  1 selects two stop bits, 0 selects one.
REQ-012 wr_valid  input  1  write request.
REQ-013 wr_ready  output  1  FIFO can accept a write.
REQ-014 wr_data  input  DATA_W  byte to queue.
REQ-015 flush  input  1  single-cycle FIFO clear.
REQ-016 fifo_level  output  $clog2(DEPTH)+1  number of queued entries.
REQ-017 busy  output  1  a frame is on the line.
REQ-018 tx_irq  output  1  asserted while fifo_level <= THRESH.
REQ-019 txd  output  1  serial line; idle level is 1.

Function
REQ-020 Push SHALL occur when wr_valid and wr_ready are both 1 in the same cycle.
REQ-021 wr_ready SHALL equal (fifo_level < DEPTH), combinational from registered state.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH; full and empty SHALL be derived from fifo_level only.
REQ-023 Simultaneous push and pop SHALL leave fifo_level unchanged and both operations SHALL take effect.
REQ-024 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-025 IDLE->START when cfg_en=1 and fifo_level>0; in that same cycle the block SHALL pop the head entry into the shift register and latch all cfg_* inputs for the frame.
REQ-026 Baud counter SHALL be cleared on entry to START and SHALL generate a bit-end tick when count==latched divisor; the counter SHALL then restart from 0.
REQ-027 START drives txd=0 for one bit period, then goes to DATA.
REQ-028 DATA shifts out LSB first for DATA_W bit periods, then goes to PARITY if parity is enabled, else to STOP.
REQ-029 Parity bit SHALL be the XOR of the data bits, inverted when odd parity is selected.
REQ-030 STOP drives txd=1 for 1 or 2 bit periods, then goes to IDLE.
REQ-031 If the FIFO is non-empty and cfg_en=1 at the end of STOP, the next START SHALL begin one cycle later (one IDLE cycle); there is no extra idle bit.
REQ-032 busy=1 in every state except IDLE.
REQ-033 txd SHALL be registered (glitch-free); a frame starts on txd one cycle after the pop.
REQ-034 flush SHALL zero fifo_level and both pointers; an in-flight frame SHALL complete unaffected; flush has priority over a coincident push, and that push is dropped.
REQ-035 Deasserting cfg_en mid-frame SHALL NOT abort the frame; no new frame starts while cfg_en=0; FIFO contents are retained.
REQ-036 Changing cfg_* mid-frame SHALL NOT affect the current frame.
REQ-037 cfg_divisor=0 SHALL give a one-cycle bit period.
REQ-038 tx_irq SHALL be registered and update one cycle after a fifo_level change.

Reset
REQ-039 While rst_n=0 the block SHALL hold: txd=1, busy=0, fifo_level=0, wr_ready=1, tx_irq=1, FSM=IDLE, baud counter=0, pointers=0.
REQ-040 Reset mid-frame SHALL abort the frame immediately, with txd returning to 1 asynchronously; FIFO data is lost.

Verification
REQ-041 DATA_W=8, divisor=3, no parity, 1 stop, write 0xA5 -> txd shows 0,1,0,1,0,0,1,0,1,1, each bit lasting 4 cycles; busy high for 40 cycles.
REQ-042 Write 0x03 with even parity, then with odd parity -> parity bit 0, then 1; cfg_stop2=1 -> stop high for 2 bit periods.
REQ-043 Write 17 entries with DEPTH=16 and cfg_en=0 -> wr_ready drops after the 16th; the 17th is not accepted; fifo_level=16; tx_irq=0.
REQ-044 Queue 3 entries, enable -> three back-to-back frames with exactly one idle cycle between them; tx_irq rises when level reaches 2.
REQ-045 Flush during frame 1 of 4 -> frame 1 completes; fifo_level=0 next cycle; no further frames.
REQ-046 Assert rst_n=0 mid DATA -> txd=1 and busy=0 immediately; after release, a new write transmits correctly.
